// File: rtl/williams_rgbi_palette.sv
// RGBI to RGB colour stage for Williams-style video: a runtime-writable lookup table
// behind a three-clock pipeline, with blanking/sync delayed to stay aligned with colour.
module williams_rgbi_palette #(
   parameter int COMP_W = 4,
   parameter int INT_W  = 4,
   parameter int OUT_W  = 8,
   parameter int CE_DIV = 8
) (
   input  logic                    clk_video,
   input  logic                    reset,
   output logic                    ce_pix,
   input  logic [COMP_W-1:0]       in_r,
   input  logic [COMP_W-1:0]       in_g,
   input  logic [COMP_W-1:0]       in_b,
   input  logic [INT_W-1:0]        in_i,
   input  logic                    in_hblank,
   input  logic                    in_vblank,
   input  logic                    in_hs,
   input  logic                    in_vs,
   input  logic                    blank_en,
   input  logic                    dim_en,
   input  logic                    lut_wr,
   input  logic [COMP_W+INT_W-1:0] lut_addr,
   input  logic [OUT_W-1:0]        lut_data,
   output logic                    lut_ready,
   output logic [OUT_W-1:0]        out_r,
   output logic [OUT_W-1:0]        out_g,
   output logic [OUT_W-1:0]        out_b,
   output logic                    out_hblank,
   output logic                    out_vblank,
   output logic                    out_hs,
   output logic                    out_vs
);
   localparam int ADDR_W = COMP_W + INT_W;
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int CE_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   init_addr_reg, init_addr_next;
   logic                wr_en;
   logic [ADDR_W-1:0]   wr_addr;
   logic [OUT_W-1:0]    wr_data;

   // Product left-aligned in OUT_W; low bits repeat the product MSBs, or it is truncated.
   function automatic logic [OUT_W-1:0] default_entry(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] p;
      logic [OUT_W-1:0]  v;
      p = ADDR_W'(addr[ADDR_W-1:INT_W]) * ADDR_W'(addr[INT_W-1:0]);
      v = '0;
      for (int k = 0; k < OUT_W; k++) begin
         v[OUT_W-1-k] = p[ADDR_W-1-(k % ADDR_W)];
      end
      return v;
   endfunction

   // Pixel clock enable
   logic [CE_W-1:0] ce_cnt_reg;
   logic            ce_pix_reg;

   always_ff @(posedge clk_video) begin
      if (reset) begin
         ce_cnt_reg <= '0;
         ce_pix_reg <= 1'b0;
      end else begin
         ce_pix_reg <= (ce_cnt_reg == '0);
         ce_cnt_reg <= (ce_cnt_reg == CE_W'(CE_DIV - 1)) ? '0 : ce_cnt_reg + 1'b1;
      end
   end

   assign ce_pix = ce_pix_reg;

   // Table initialisation / host write FSM
   always_ff @(posedge clk_video) begin
      if (reset) begin
         state_reg     <= ST_INIT;
         init_addr_reg <= '0;
      end else begin
         state_reg     <= state_next;
         init_addr_reg <= init_addr_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      init_addr_next = init_addr_reg;
      wr_en          = 1'b0;
      wr_addr        = lut_addr;
      wr_data        = lut_data;
      case (state_reg)
         ST_INIT: begin
            wr_en          = !reset;
            wr_addr        = init_addr_reg;
            wr_data        = default_entry(init_addr_reg);
            init_addr_next = init_addr_reg + 1'b1;
            if (init_addr_reg == '1) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            wr_en = lut_wr && !reset;
         end
         default: begin
            state_next = ST_INIT;
         end
      endcase
   end

   assign lut_ready = (state_reg == ST_RUN);

   // Pipeline stages; timing bits packed as {hblank, vblank, hs, vs}, modes as {blank_en, dim_en}
   logic [3*COMP_W-1:0] s1_rgb_reg;
   logic [INT_W-1:0]    s1_i_reg, s2_i_reg;
   logic [3:0]          s1_tim_reg, s2_tim_reg, s3_tim_reg;
   logic [1:0]          s1_mode_reg, s2_mode_reg;

   always_ff @(posedge clk_video) begin
      if (reset) begin
         s1_rgb_reg  <= '0;
         s1_i_reg    <= '0;
         s1_tim_reg  <= '0;
         s1_mode_reg <= '0;
         s2_i_reg    <= '0;
         s2_tim_reg  <= '0;
         s2_mode_reg <= '0;
         s3_tim_reg  <= '0;
      end else begin
         s1_rgb_reg  <= {in_b, in_g, in_r};
         s1_i_reg    <= in_i;
         s1_tim_reg  <= {in_hblank, in_vblank, in_hs, in_vs};
         s1_mode_reg <= {blank_en, dim_en};
         s2_i_reg    <= s1_i_reg;
         s2_tim_reg  <= s1_tim_reg;
         s2_mode_reg <= s1_mode_reg;
         s3_tim_reg  <= s2_tim_reg;
      end
   end

   logic force_black;
   assign force_black = (s2_i_reg == '0) || !lut_ready ||
                        (s2_mode_reg[1] && (s2_tim_reg[3] || s2_tim_reg[2]));

   logic [3*OUT_W-1:0] out_rgb;

   // One table copy per channel so all three reads happen in the same cycle
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         logic [OUT_W-1:0] lut_mem [0:DEPTH-1];
         logic [OUT_W-1:0] lut_q_reg;
         logic [OUT_W-1:0] colour_reg;

         always_ff @(posedge clk_video) begin
            if (wr_en) begin
               lut_mem[wr_addr] <= wr_data;
            end
            lut_q_reg <= lut_mem[{s1_rgb_reg[gi*COMP_W +: COMP_W], s1_i_reg}];
         end

         always_ff @(posedge clk_video) begin
            if (reset || force_black) begin
               colour_reg <= '0;
            end else if (s2_mode_reg[0]) begin
               colour_reg <= lut_q_reg >> 1;
            end else begin
               colour_reg <= lut_q_reg;
            end
         end

         assign out_rgb[gi*OUT_W +: OUT_W] = colour_reg;
      end
   endgenerate

   assign out_r = out_rgb[0*OUT_W +: OUT_W];
   assign out_g = out_rgb[1*OUT_W +: OUT_W];
   assign out_b = out_rgb[2*OUT_W +: OUT_W];

   assign {out_hblank, out_vblank, out_hs, out_vs} = s3_tim_reg;

endmodule

// File: tb/tb_williams_rgbi_palette.sv
// Bench for williams_rgbi_palette: table vectors, hand sequences and random traffic
// checked every cycle against a history-based reference model.
module tb_williams_rgbi_palette;
   logic clk_video = 1'b0;
   always #5 clk_video = ~clk_video;

   logic       reset = 1'b1;
   logic [3:0] in_r = '0, in_g = '0, in_b = '0, in_i = '0;
   logic       in_hblank = 0, in_vblank = 0, in_hs = 0, in_vs = 0;
   logic       blank_en = 0, dim_en = 0, lut_wr = 0;
   logic [7:0] lut_addr = '0, lut_data = '0;

   logic       ce_pix, lut_ready, out_hblank, out_vblank, out_hs, out_vs;
   logic [7:0] out_r, out_g, out_b;
   logic       ce_pix4, lut_ready4, out_hblank4, out_vblank4, out_hs4, out_vs4;
   logic [7:0] out_r4, out_g4, out_b4;

   williams_rgbi_palette #(.COMP_W(4), .INT_W(4), .OUT_W(8), .CE_DIV(8)) u_dut (
      .clk_video(clk_video), .reset(reset), .ce_pix(ce_pix),
      .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_i(in_i),
      .in_hblank(in_hblank), .in_vblank(in_vblank), .in_hs(in_hs), .in_vs(in_vs),
      .blank_en(blank_en), .dim_en(dim_en),
      .lut_wr(lut_wr), .lut_addr(lut_addr), .lut_data(lut_data), .lut_ready(lut_ready),
      .out_r(out_r), .out_g(out_g), .out_b(out_b),
      .out_hblank(out_hblank), .out_vblank(out_vblank), .out_hs(out_hs), .out_vs(out_vs)
   );

   williams_rgbi_palette #(.COMP_W(4), .INT_W(4), .OUT_W(8), .CE_DIV(4)) u_dut4 (
      .clk_video(clk_video), .reset(reset), .ce_pix(ce_pix4),
      .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_i(in_i),
      .in_hblank(in_hblank), .in_vblank(in_vblank), .in_hs(in_hs), .in_vs(in_vs),
      .blank_en(blank_en), .dim_en(dim_en),
      .lut_wr(lut_wr), .lut_addr(lut_addr), .lut_data(lut_data), .lut_ready(lut_ready4),
      .out_r(out_r4), .out_g(out_g4), .out_b(out_b4),
      .out_hblank(out_hblank4), .out_vblank(out_vblank4), .out_hs(out_hs4), .out_vs(out_vs4)
   );

   int errors = 0;
   int checks = 0;

   // Reference model state: table contents (-1 = never written), ready flag, history of pixels
   typedef struct packed {
      int r, g, b, i;
      bit hb, vb, hs, vs, ben, den, rst;
      int lr, lg, lb;
   } rec_t;

   rec_t hist[$];
   int   ref_lut[256];
   bit   model_ready = 0;
   int   init_cnt = 0;
   int   since_rel = 0;

   typedef struct {
      string name;
      int r, g, b, i;
      bit hb, vb, ben, den;
      int er, eg, eb;
   } vec_t;

   vec_t vecs[9];

   function automatic int default_val(input int a);
      return (a / 16) * (a % 16);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic tick();
      rec_t t, nr, src;
      bit   ready_before, exp_ce, exp_ce4, known;
      int   er, eg, eb;
      @(posedge clk_video);
      // The pixel captured one edge ago reads the table now, before this edge's write lands
      if (hist.size() > 0) begin
         t = hist[hist.size()-1];
         t.lr = ref_lut[t.r*16 + t.i];
         t.lg = ref_lut[t.g*16 + t.i];
         t.lb = ref_lut[t.b*16 + t.i];
         hist[hist.size()-1] = t;
      end
      ready_before = model_ready;
      nr = '0;
      if (!reset) begin
         nr.r = int'(in_r); nr.g = int'(in_g); nr.b = int'(in_b); nr.i = int'(in_i);
         nr.hb = in_hblank; nr.vb = in_vblank; nr.hs = in_hs; nr.vs = in_vs;
         nr.ben = blank_en; nr.den = dim_en;
      end
      nr.rst = reset;
      hist.push_back(nr);
      exp_ce = 0;
      exp_ce4 = 0;
      if (reset) begin
         model_ready = 0;
         init_cnt = 0;
         since_rel = 0;
      end else begin
         exp_ce = (since_rel % 8) == 0;
         exp_ce4 = (since_rel % 4) == 0;
         since_rel++;
         if (!model_ready) begin
            ref_lut[init_cnt] = default_val(init_cnt);
            init_cnt++;
            if (init_cnt == 256) model_ready = 1;
         end else if (lut_wr) begin
            ref_lut[lut_addr] = int'(lut_data);
         end
      end
      src = '0;
      if (!reset && hist.size() >= 3 && !hist[hist.size()-2].rst) src = hist[hist.size()-3];
      known = 1;
      er = 0; eg = 0; eb = 0;
      if (!(src.i == 0 || !ready_before || (src.ben && (src.hb || src.vb)))) begin
         if (src.lr < 0 || src.lg < 0 || src.lb < 0) known = 0;
         er = src.lr >> src.den;
         eg = src.lg >> src.den;
         eb = src.lb >> src.den;
      end
      while (hist.size() > 3) t = hist.pop_front();
      #1;
      chk("ce_pix", ce_pix, exp_ce);
      chk("ce_pix_div4", ce_pix4, exp_ce4);
      chk("lut_ready", lut_ready, model_ready);
      chk("lut_ready_div4", lut_ready4, model_ready);
      chk("timing", {out_hblank, out_vblank, out_hs, out_vs}, {src.hb, src.vb, src.hs, src.vs});
      chk("timing_div4", {out_hblank4, out_vblank4, out_hs4, out_vs4}, {src.hb, src.vb, src.hs, src.vs});
      if (known) begin
         chk("model_rgb", {out_r, out_g, out_b}, {8'(er), 8'(eg), 8'(eb)});
         chk("model_rgb_div4", {out_r4, out_g4, out_b4}, {8'(er), 8'(eg), 8'(eb)});
      end
   endtask

   task automatic set_pix(input int r, input int g, input int b, input int i);
      in_r = 4'(r); in_g = 4'(g); in_b = 4'(b); in_i = 4'(i);
   endtask

   task automatic wait_init(input string tag);
      for (int n = 1; n <= 256; n++) begin
         in_hs = 1'($urandom); in_vs = 1'($urandom);
         set_pix($urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15));
         tick();
         if (n < 4 || n > 252) chk({tag, "_ready"}, lut_ready, (n >= 256) ? 1'b1 : 1'b0);
         if (n > 3 && n < 256) chk({tag, "_black"}, {out_r, out_g, out_b}, 24'd0);
      end
      $display("%s: lut_ready after 256 cycles = %0d", tag, lut_ready);
   endtask

   task automatic hold3();
      tick(); tick(); tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int k = 0; k < 256; k++) ref_lut[k] = -1;
      vecs[0] = '{"r15g3b0i15", 15, 3, 0, 15, 0, 0, 0, 0, 225, 45, 0};
      vecs[1] = '{"r3i5",       3, 0, 0, 5,   0, 0, 0, 0, 15, 0, 0};
      vecs[2] = '{"i0_white",   15, 15, 15, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[3] = '{"blank_hb",   15, 15, 15, 15, 1, 0, 1, 0, 0, 0, 0};
      vecs[4] = '{"noblank_hb", 15, 0, 0, 15, 1, 0, 0, 0, 225, 0, 0};
      vecs[5] = '{"dim",        15, 0, 0, 15, 0, 0, 0, 1, 112, 0, 0};
      vecs[6] = '{"blank_vb",   15, 15, 15, 15, 0, 1, 1, 0, 0, 0, 0};
      vecs[7] = '{"r1g2b4i1",   1, 2, 4, 1,   0, 0, 0, 0, 1, 2, 4};
      vecs[8] = '{"r15g1b8i8",  15, 1, 8, 8,  0, 0, 1, 1, 60, 4, 32};

      // Reset, then the full initialisation sweep
      reset = 1;
      tick(); tick(); tick();
      chk("reset_rgb", {out_r, out_g, out_b}, 24'd0);
      chk("reset_ready", lut_ready, 1'b0);
      reset = 0;
      wait_init("init");
      in_hs = 0; in_vs = 0;

      // Latency: two back-to-back pixels appear three clocks after they are driven
      set_pix(15, 3, 0, 15); tick();
      set_pix(3, 0, 0, 5);   tick();
      set_pix(0, 0, 0, 0);   tick();
      chk("lat_first", {out_r, out_g, out_b}, {8'd225, 8'd45, 8'd0});
      tick();
      chk("lat_second", out_r, 8'd15);
      tick();
      chk("lat_after", out_r, 8'd0);
      $display("latency: pixel pair checked");

      for (int v = 0; v < 9; v++) begin
         set_pix(vecs[v].r, vecs[v].g, vecs[v].b, vecs[v].i);
         in_hblank = vecs[v].hb; in_vblank = vecs[v].vb;
         blank_en = vecs[v].ben; dim_en = vecs[v].den;
         hold3();
         chk({"vec_", vecs[v].name}, {out_r, out_g, out_b},
             {8'(vecs[v].er), 8'(vecs[v].eg), 8'(vecs[v].eb)});
         $display("vector %s: rgb=%0d/%0d/%0d", vecs[v].name, out_r, out_g, out_b);
      end
      in_hblank = 0; in_vblank = 0; dim_en = 0;

      // Blanking window: colour is black exactly while the delayed hblank is high
      blank_en = 1;
      set_pix(15, 0, 0, 15);
      hold3();
      for (int k = 0; k < 8; k++) begin
         in_hblank = (k == 2 || k == 3);
         tick();
         chk("win_hblank", out_hblank, (k == 4 || k == 5) ? 1'b1 : 1'b0);
         chk("win_r", out_r, (k == 4 || k == 5) ? 8'd0 : 8'd225);
      end
      $display("blank window: checked");
      blank_en = 0; in_hblank = 0;

      // Host write to the last address, used two cycles later on all channels
      set_pix(0, 0, 0, 0);
      lut_wr = 1; lut_addr = 8'hFF; lut_data = 8'hFF;
      tick();
      lut_wr = 0;
      tick();
      set_pix(15, 15, 15, 15);
      hold3();
      chk("host_ff", {out_r, out_g, out_b}, {8'd255, 8'd255, 8'd255});
      $display("host write 0xFF: rgb=%0d/%0d/%0d", out_r, out_g, out_b);

      // Write and read of the same address on one edge returns the old entry
      set_pix(2, 0, 0, 2); tick();
      lut_wr = 1; lut_addr = 8'h22; lut_data = 8'h99; tick();
      lut_wr = 0; set_pix(0, 0, 0, 0); tick();
      chk("collide_old", out_r, 8'd4);
      tick();
      chk("collide_new", out_r, 8'd153);
      $display("same-cycle write/read: old=4 then new=153 checked");

      // Random traffic against the model
      for (int n = 0; n < 400; n++) begin
         set_pix($urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15));
         in_hblank = ($urandom_range(3) == 0); in_vblank = ($urandom_range(7) == 0);
         in_hs = 1'($urandom); in_vs = 1'($urandom);
         blank_en = 1'($urandom); dim_en = 1'($urandom);
         lut_wr = ($urandom_range(7) == 0);
         lut_addr = 8'($urandom); lut_data = 8'($urandom);
         tick();
      end
      lut_wr = 0; blank_en = 0; dim_en = 0; in_hblank = 0; in_vblank = 0;
      $display("random: 400 cycles, errors so far %0d", errors);

      // Reset in RUN, then again mid-INIT at address 100
      reset = 1; tick(); reset = 0;
      for (int n = 0; n < 100; n++) tick();
      chk("mid_init_ready", lut_ready, 1'b0);
      reset = 1; tick(); reset = 0;
      wait_init("reinit");
      in_hs = 0; in_vs = 0;
      set_pix(2, 0, 15, 2); hold3();
      chk("restore_22", {out_r, out_b}, {8'd4, 8'd30});
      set_pix(15, 15, 15, 15); hold3();
      chk("restore_ff", {out_r, out_g, out_b}, {8'd225, 8'd225, 8'd225});

      // Reset after a host write restores the default entry
      lut_wr = 1; lut_addr = 8'h35; lut_data = 8'hAA; tick();
      lut_wr = 0;
      set_pix(3, 0, 0, 5); hold3();
      chk("host_35", out_r, 8'd170);
      reset = 1; tick(); reset = 0;
      wait_init("reinit2");
      set_pix(3, 0, 0, 5); hold3();
      chk("restore_35", out_r, 8'd15);
      $display("reset restore: out_r=%0d", out_r);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
